capture_ctrl: RTL and testbench

Capture sequencer between the LVDS receiver and `packer8to32`. Host arms it; it waits for a trigger byte, forwards a gated byte stream to the packer, counts completed 32-bit words, and stops on a word boundary at the programmed count or on an abort. It also flags downstream overflow and byte misalignment across strobe gaps.

---
 rtl/capture_ctrl_if.sv | 49 ++++
 rtl/capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_capture_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: bundles the host control, LVDS byte stream, packer-side
// stream and status signals of capture_ctrl.
//   master : host / LVDS side (drives controls and the input byte stream)
//   slave  : capture_ctrl (drives the gated byte stream and status)
// Signals:
//   arm, stop                 start / abort pulses
//   cfg_words                 words to capture (0 = continuous)
//   trig_mode                 0 = first strobed byte, 1 = pattern match
//   trig_value, trig_mask     pattern compare operands
//   valid_in, data_in         LVDS strobe and byte
//   fifo_full                 downstream word FIFO full
//   pk_valid, pk_data         gated byte stream to the packer
//   armed, busy, done         sequencer status
//   words_cnt                 words completed since arm
//   ovf, misalign             sticky error flags
interface capture_ctrl_if #(
  parameter int LVDS_LEN = 8,
  parameter int CNT_W    = 16
);
  logic                arm;
  logic                stop;
  logic [CNT_W-1:0]    cfg_words;
  logic                trig_mode;
  logic [LVDS_LEN-1:0] trig_value;
  logic [LVDS_LEN-1:0] trig_mask;
  logic                valid_in;
  logic [LVDS_LEN-1:0] data_in;
  logic                fifo_full;
  logic                pk_valid;
  logic [LVDS_LEN-1:0] pk_data;
  logic                armed;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    words_cnt;
  logic                ovf;
  logic                misalign;

  modport master (
    output arm, stop, cfg_words, trig_mode, trig_value, trig_mask,
           valid_in, data_in, fifo_full,
    input  pk_valid, pk_data, armed, busy, done, words_cnt, ovf, misalign
  );

  modport slave (
    input  arm, stop, cfg_words, trig_mode, trig_value, trig_mask,
           valid_in, data_in, fifo_full,
    output pk_valid, pk_data, armed, busy, done, words_cnt, ovf, misalign
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer between the LVDS receiver and the 8-to-32
// packer. Armed by the host, it waits for a trigger byte, forwards a gated
// byte stream, counts completed words and stops on a word boundary at the
// programmed count or on abort. Flags downstream overflow and byte
// misalignment across long strobe gaps.
// Ports:
//   clk  capture clock (LVDS ClockOUT)
//   rst  synchronous, active-high reset
//   bus  capture_ctrl_if slave modport (controls, byte streams, status)
module capture_ctrl #(
  parameter int LVDS_LEN = 8,
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = 16,
  parameter int GAP_LEN  = 16
) (
  input logic          clk,
  input logic          rst,
  capture_ctrl_if.slave bus
);

  localparam int BPW   = DATA_LEN / LVDS_LEN;
  localparam int PH_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int GAP_W = $clog2(GAP_LEN + 1);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(BPW - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  // configuration latched on arm
  logic [CNT_W-1:0]    cfg_words_q;
  logic                trig_mode_q;
  logic [LVDS_LEN-1:0] trig_value_q;
  logic [LVDS_LEN-1:0] trig_mask_q;

  logic [PH_W-1:0]     phase;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CNT_W-1:0]    words_cnt_q;
  logic                ovf_q;
  logic                misalign_q;
  logic                pk_valid_q;
  logic [LVDS_LEN-1:0] pk_data_q;

  logic                in_stream;
  logic                arm_ok;
  logic                trig_hit;
  logic                trig_take;
  logic                fwd;
  logic                word_end;
  logic [CNT_W-1:0]    words_inc;
  logic                cnt_hit;
  logic                gap_hit;
  logic [PH_W-1:0]     phase_adv;
  logic [PH_W-1:0]     phase_eff;

  assign in_stream = (state == S_CAPTURE) || (state == S_DRAIN);
  assign arm_ok    = bus.arm && ((state == S_IDLE) || (state == S_DONE));
  assign trig_hit  = bus.valid_in &&
                     (!trig_mode_q ||
                      ((bus.data_in & trig_mask_q) == (trig_value_q & trig_mask_q)));
  // an abort in ARMED wins over a coincident trigger: nothing is forwarded
  assign trig_take = (state == S_ARMED) && !bus.stop && trig_hit;
  assign fwd       = trig_take || (in_stream && bus.valid_in);
  assign word_end  = in_stream && bus.valid_in && (phase == LAST_PH);
  assign words_inc = words_cnt_q + CNT_W'(1);
  assign cnt_hit   = word_end && (cfg_words_q != '0) && (words_inc == cfg_words_q);
  // fires on the cycle the gap counter reaches GAP_LEN (only once, it saturates)
  assign gap_hit   = in_stream && !bus.valid_in && (gap_cnt == GAP_LAST);
  assign phase_adv = (phase == LAST_PH) ? '0 : phase + PH_W'(1);
  // phase after this cycle's byte; decides whether a stop lands on a boundary
  assign phase_eff = (in_stream && bus.valid_in) ? phase_adv : phase;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.arm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (bus.stop)    state_nxt = S_IDLE;
        else if (trig_hit) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cnt_hit)       state_nxt = S_DONE;
        else if (bus.stop) state_nxt = (phase_eff == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (word_end || gap_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = bus.arm ? S_ARMED : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // status outputs; DONE lasts exactly one cycle so it doubles as the pulse
  always_comb begin
    bus.armed = (state == S_ARMED);
    bus.busy  = (state == S_ARMED) || (state == S_CAPTURE) || (state == S_DRAIN);
    bus.done  = (state == S_DONE);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_words_q  <= '0;
      trig_mode_q  <= 1'b0;
      trig_value_q <= '0;
      trig_mask_q  <= '0;
      phase        <= '0;
      gap_cnt      <= '0;
      words_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      misalign_q   <= 1'b0;
      pk_valid_q   <= 1'b0;
      pk_data_q    <= '0;
    end else begin
      pk_valid_q <= fwd;
      if (fwd) pk_data_q <= bus.data_in;

      if (arm_ok) begin
        cfg_words_q  <= bus.cfg_words;
        trig_mode_q  <= bus.trig_mode;
        trig_value_q <= bus.trig_value;
        trig_mask_q  <= bus.trig_mask;
        phase        <= '0;
        gap_cnt      <= '0;
        words_cnt_q  <= '0;
        ovf_q        <= 1'b0;
        misalign_q   <= 1'b0;
      end else begin
        // phase is 0 in ARMED, so the trigger byte advances it to 1
        if (fwd) phase <= phase_adv;
        if (word_end) words_cnt_q <= words_inc;

        if (bus.valid_in)                      gap_cnt <= '0;
        else if (in_stream && gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GAP_W'(1);

        if (fwd && bus.fifo_full) ovf_q <= 1'b1;
        // phase is never 0 in DRAIN, so this covers both CAPTURE and DRAIN
        if (gap_hit && phase != '0) misalign_q <= 1'b1;
      end
    end
  end

  assign bus.pk_valid  = pk_valid_q;
  assign bus.pk_data   = pk_data_q;
  assign bus.words_cnt = words_cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed table-driven bench for capture_ctrl, plus
// hand-written sequences for drain, gap/misalign, overflow and reset.
module tb_capture_ctrl;
  localparam int LVDS_LEN = 8;
  localparam int DATA_LEN = 32;
  localparam int CNT_W    = 16;
  localparam int GAP_LEN  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  capture_ctrl_if #(.LVDS_LEN(LVDS_LEN), .CNT_W(CNT_W)) bus ();

  capture_ctrl #(
    .LVDS_LEN(LVDS_LEN), .DATA_LEN(DATA_LEN), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // packer model: little-endian byte assembly of the forwarded stream
  logic [31:0] pk_word;
  int          pk_ph = 0;
  logic [31:0] words_q[$];

  typedef struct {
    logic        r, a, s, v;
    logic [7:0]  d;
    logic [15:0] cfg;
    logic        mode;
    logic [7:0]  tv, tm;
    logic        pkv;
    logic [7:0]  pkd;
    logic        ea, eb, ed;
    logic [15:0] ec;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] cur_cfg;
  logic        cur_mode;
  logic [7:0]  cur_tv, cur_tm;

  function automatic void add(input logic r, a, s, v, input logic [7:0] d,
                              input logic pkv, input logic [7:0] pkd,
                              input logic ea, eb, ed, input logic [15:0] ec);
    vec_t x;
    x.r = r; x.a = a; x.s = s; x.v = v; x.d = d;
    x.cfg = cur_cfg; x.mode = cur_mode; x.tv = cur_tv; x.tm = cur_tm;
    x.pkv = pkv; x.pkd = pkd; x.ea = ea; x.eb = eb; x.ed = ed; x.ec = ec;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // fields: {pk_valid, armed, busy, done, words_cnt, ovf, misalign}
  task automatic chk_all(input string nm, input logic pkv, input logic [7:0] pkd,
                         input logic a, b, d, input logic [15:0] cnt,
                         input logic o, m);
    chk(nm, 64'({bus.pk_valid, bus.armed, bus.busy, bus.done, bus.words_cnt,
                 bus.ovf, bus.misalign}),
            64'({pkv, a, b, d, cnt, o, m}));
    if (pkv) chk($sformatf("%s/data", nm), 64'(bus.pk_data), 64'(pkd));
  endtask

  task automatic pk_clear();
    pk_ph = 0;
    words_q.delete();
  endtask

  task automatic tick(input logic r, a, s, v, input logic [7:0] d, input logic ff);
    rst = r; bus.arm = a; bus.stop = s; bus.valid_in = v;
    bus.data_in = d; bus.fifo_full = ff;
    @(posedge clk);
    #1;
    if (r) pk_ph = 0;
    else if (bus.pk_valid) begin
      pk_word[pk_ph*8 +: 8] = bus.pk_data;
      if (pk_ph == 3) begin
        words_q.push_back(pk_word);
        pk_ph = 0;
      end else pk_ph++;
    end
    rst = 1'b0; bus.arm = 1'b0; bus.stop = 1'b0; bus.valid_in = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic send(input int first, input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 1, 8'(first + k), 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic set_cfg(input logic [15:0] c, input logic m,
                         input logic [7:0] tv, input logic [7:0] tm);
    bus.cfg_words = c; bus.trig_mode = m; bus.trig_value = tv; bus.trig_mask = tm;
  endtask

  task automatic chk_words(input string nm, input logic [31:0] exp[$]);
    chk($sformatf("%s/nwords", nm), 64'(words_q.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < words_q.size(); k++)
      chk($sformatf("%s/word%0d", nm, k), 64'(words_q[k]), 64'(exp[k]));
  endtask

  initial begin
    rst = 1'b1;
    set_cfg(16'd0, 1'b0, 8'h00, 8'h00);
    bus.arm = 1'b0; bus.stop = 1'b0; bus.valid_in = 1'b0;
    bus.data_in = 8'h00; bus.fifo_full = 1'b0;

    // ---- table: count stop, pattern trigger, masked trigger ----
    cur_cfg = 16'd3; cur_mode = 1'b0; cur_tv = 8'h00; cur_tm = 8'h00;
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 16'd0);   // reset
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 16'd0);   // stop in IDLE: no effect
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 16'd0);   // arm
    add(0, 0, 0, 0, 8'h77, 0, 8'h00, 1, 1, 0, 16'd0);   // no strobe: stay armed
    for (int k = 1; k <= 12; k++)                        // arm at byte 5 is ignored
      add(0, (k == 5), 0, 1, 8'(k), 1, 8'(k), 0, (k != 12), (k == 12), 16'(k / 4));
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 16'd3);   // back to IDLE

    cur_cfg = 16'd1; cur_mode = 1'b1; cur_tv = 8'hA5; cur_tm = 8'hFF;
    add(0, 1, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 16'd0);   // arm + stop: arm wins
    add(0, 0, 0, 1, 8'h11, 0, 8'h00, 1, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'h22, 0, 8'h00, 1, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'hA5, 1, 8'hA5, 0, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'hB0, 1, 8'hB0, 0, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'hB1, 1, 8'hB1, 0, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'hB2, 1, 8'hB2, 0, 0, 1, 16'd1);

    cur_cfg = 16'd1; cur_mode = 1'b1; cur_tv = 8'hA0; cur_tm = 8'hF0;
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 16'd0);   // arm from DONE
    add(0, 0, 0, 1, 8'h5A, 0, 8'h00, 1, 1, 0, 16'd0);   // masked mismatch
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 16'd0);   // stop in ARMED
    add(0, 0, 0, 1, 8'hA7, 0, 8'h00, 0, 0, 0, 16'd0);   // IDLE: not forwarded
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'hA7, 1, 8'hA7, 0, 1, 0, 16'd0);   // masked match
    add(0, 0, 0, 1, 8'h01, 1, 8'h01, 0, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'h02, 1, 8'h02, 0, 1, 0, 16'd0);
    add(0, 0, 0, 1, 8'h03, 1, 8'h03, 0, 0, 1, 16'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      set_cfg(tbl[i].cfg, tbl[i].mode, tbl[i].tv, tbl[i].tm);
      tick(tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].v, tbl[i].d, 1'b0);
      chk_all($sformatf("vec%0d", i), tbl[i].pkv, tbl[i].pkd,
              tbl[i].ea, tbl[i].eb, tbl[i].ed, tbl[i].ec, 1'b0, 1'b0);
      if (tbl[i].r) chk("reset/pk_data", 64'(bus.pk_data), 64'd0);
    end
    chk_words("table", '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                         32'hB2B1B0A5, 32'h030201A7});

    // ---- stop mid-word: drain to the word boundary ----
    pk_clear();
    set_cfg(16'd0, 1'b0, 8'h00, 8'h00);
    tick(0, 1, 0, 0, 8'h00, 0);
    send(1, 6);
    tick(0, 0, 1, 0, 8'h00, 0);
    chk_all("drain/entry", 0, 8'h00, 0, 1, 0, 16'd1, 0, 0);
    send(7, 1);
    chk_all("drain/b7", 1, 8'h07, 0, 1, 0, 16'd1, 0, 0);
    send(8, 1);
    chk_all("drain/b8", 1, 8'h08, 0, 0, 1, 16'd2, 0, 0);
    chk_words("drain", '{32'h04030201, 32'h08070605});

    // ---- drain abandoned by a long gap ----
    tick(0, 1, 0, 0, 8'h00, 0);
    send(1, 6);
    tick(0, 0, 1, 0, 8'h00, 0);
    idle(14);
    chk_all("dgap/15", 0, 8'h00, 0, 1, 0, 16'd1, 0, 0);
    idle(1);
    chk_all("dgap/16", 0, 8'h00, 0, 0, 1, 16'd1, 0, 1);
    idle(1);
    chk_all("dgap/sticky", 0, 8'h00, 0, 0, 0, 16'd1, 0, 1);

    // ---- gap in CAPTURE at phase 2: flag, keep capturing ----
    tick(0, 1, 0, 0, 8'h00, 0);
    chk_all("cgap/arm", 0, 8'h00, 1, 1, 0, 16'd0, 0, 0);
    send(1, 2);
    idle(15);
    chk_all("cgap/15", 0, 8'h00, 0, 1, 0, 16'd0, 0, 0);
    idle(1);
    chk_all("cgap/16", 0, 8'h00, 0, 1, 0, 16'd0, 0, 1);
    send(3, 2);
    chk_all("cgap/word", 1, 8'h04, 0, 1, 0, 16'd1, 0, 1);
    tick(0, 0, 1, 0, 8'h00, 0);
    chk_all("cgap/stop", 0, 8'h00, 0, 0, 1, 16'd1, 0, 1);

    // ---- same gap at phase 0: no flag ----
    tick(0, 1, 0, 0, 8'h00, 0);
    send(1, 4);
    idle(20);
    chk_all("zgap/20", 0, 8'h00, 0, 1, 0, 16'd1, 0, 0);
    tick(0, 0, 1, 0, 8'h00, 0);
    chk_all("zgap/stop", 0, 8'h00, 0, 0, 1, 16'd1, 0, 0);

    // ---- overflow: sticky, no backpressure, cleared by arm ----
    tick(0, 1, 0, 0, 8'h00, 0);
    send(1, 1);
    tick(0, 0, 0, 1, 8'h02, 1);
    chk_all("ovf/set", 1, 8'h02, 0, 1, 0, 16'd0, 1, 0);
    send(3, 2);
    chk_all("ovf/hold", 1, 8'h04, 0, 1, 0, 16'd1, 1, 0);
    tick(0, 0, 1, 0, 8'h00, 0);
    chk_all("ovf/done", 0, 8'h00, 0, 0, 1, 16'd1, 1, 0);
    idle(1);
    tick(0, 1, 0, 0, 8'h00, 0);
    chk_all("ovf/clear", 0, 8'h00, 1, 1, 0, 16'd0, 0, 0);
    tick(0, 0, 1, 0, 8'h00, 0);

    // ---- reset mid-word, then a clean 2-word capture ----
    set_cfg(16'd2, 1'b0, 8'h00, 8'h00);
    tick(0, 1, 0, 0, 8'h00, 0);
    send(1, 2);
    tick(1, 0, 0, 1, 8'h03, 0);
    chk_all("rst/mid", 0, 8'h00, 0, 0, 0, 16'd0, 0, 0);
    chk("rst/mid/pk_data", 64'(bus.pk_data), 64'd0);
    pk_clear();
    tick(0, 1, 0, 0, 8'h00, 0);
    send(8'h10, 7);
    chk_all("rearm/b7", 1, 8'h16, 0, 1, 0, 16'd1, 0, 0);
    send(8'h17, 1);
    chk_all("rearm/b8", 1, 8'h17, 0, 0, 1, 16'd2, 0, 0);
    chk_words("rearm", '{32'h13121110, 32'h17161514});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
